usb_rx_deframer: RTL and testbench

//  Sits between the sys_clk side of the RX CDC FIFO and the USB subsystem's

---
 rtl/usb_rx_deframer.sv | 167 ++++++++++++++++
 tb/tb_usb_rx_deframer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_deframer.sv
// USB RX deframer: hunts for sync headers in the host word stream and
// routes each frame's payload to one channel as a valid/ready/last stream.
module usb_rx_deframer #(
    parameter int          NumChannels   = 2,
    parameter int          TimeoutCycles = 4096,
    parameter logic [7:0]  SyncByte      = 8'hA5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [31:0]            ch_data_o,
    output logic [NumChannels-1:0] ch_valid_o,
    output logic                   ch_last_o,
    input  logic [NumChannels-1:0] ch_ready_i,
    output logic [NumChannels-1:0] ch_abort_o,
    output logic [15:0]            sync_err_cnt_o,
    output logic [15:0]            drop_cnt_o,
    output logic [15:0]            timeout_cnt_o
);

    localparam int CW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int IW = $clog2(TimeoutCycles + 1);
    localparam logic [8:0] NCH = 9'(NumChannels);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ch_q, ch_d, out_ch_q;
    logic [15:0]            rem_q, rem_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic                   out_vld_q, out_last_q;
    logic [31:0]            out_data_q;
    logic [NumChannels-1:0] abort_q, abort_d, ch_oh;
    logic [15:0]            sync_cnt_q, drop_cnt_q, tmo_cnt_q;
    logic                   sync_inc, drop_inc, tmo_inc, load;
    logic                   accept, out_take, hdr_sync, hdr_ch_ok;
    logic [7:0]             hdr_ch;
    logic [15:0]            hdr_len;

    assign hdr_ch    = rx_data_i[23:16];
    assign hdr_len   = rx_data_i[15:0];
    assign hdr_sync  = (rx_data_i[31:24] == SyncByte);
    assign hdr_ch_ok = ({1'b0, hdr_ch} < NCH);

    always_comb begin
        ch_valid_o = '0;
        ch_oh      = '0;
        for (int i = 0; i < NumChannels; i++) begin
            ch_valid_o[i] = out_vld_q && (out_ch_q == CW'(i));
            ch_oh[i]      = (ch_q == CW'(i));
        end
    end

    // A held word only leaves on its own channel's ready.
    assign out_take   = |(ch_valid_o & ch_ready_i);
    assign rx_ready_o = (state_q == PAYLOAD) ? (!out_vld_q || out_take) : 1'b1;
    assign accept     = rx_valid_i && rx_ready_o;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        rem_d    = rem_q;
        idle_d   = '0;
        abort_d  = '0;
        sync_inc = 1'b0;
        drop_inc = 1'b0;
        tmo_inc  = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (accept) begin
                    if (!hdr_sync) begin
                        sync_inc = 1'b1;
                    end else if (!hdr_ch_ok) begin
                        drop_inc = 1'b1;
                        if (hdr_len != 16'd0) begin
                            rem_d   = hdr_len;
                            state_d = DRAIN;
                        end
                    end else if (hdr_len != 16'd0) begin
                        ch_d    = hdr_ch[CW-1:0];
                        rem_d   = hdr_len;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD, DRAIN: begin
                if (accept) begin
                    load  = (state_q == PAYLOAD);
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = HUNT;
                    end
                end else if (!rx_valid_i) begin
                    if (idle_q == IDLE_LAST) begin
                        tmo_inc = 1'b1;
                        state_d = HUNT;
                        if (state_q == PAYLOAD) begin
                            abort_d = ch_oh;
                        end
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    // input stalled by a blocked output: not idle
                    idle_d = idle_q;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            ch_q       <= '0;
            rem_q      <= '0;
            idle_q     <= '0;
            abort_q    <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            sync_cnt_q <= '0;
            drop_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rem_q   <= rem_d;
            idle_q  <= idle_d;
            abort_q <= abort_d;
            if (load) begin
                out_vld_q  <= 1'b1;
                out_data_q <= rx_data_i;
                out_last_q <= (rem_q == 16'd1);
                out_ch_q   <= ch_q;
            end else if (out_take) begin
                out_vld_q <= 1'b0;
            end
            if (sync_inc && (sync_cnt_q != 16'hFFFF)) begin
                sync_cnt_q <= sync_cnt_q + 16'd1;
            end
            if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (tmo_inc && (tmo_cnt_q != 16'hFFFF)) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    assign ch_data_o      = out_data_q;
    assign ch_last_o      = out_vld_q && out_last_q;
    assign ch_abort_o     = abort_q;
    assign sync_err_cnt_o = sync_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign timeout_cnt_o  = tmo_cnt_q;

endmodule

// File: tb/tb_usb_rx_deframer.sv
// Bench for usb_rx_deframer: frame-level reference model with per-channel
// expected-word queues, checked every cycle, plus directed literal checks.
module tb_usb_rx_deframer;

    localparam int NCH = 2;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [31:0] ch_data_o;
    logic [1:0]  ch_valid_o;
    logic        ch_last_o;
    logic [1:0]  ch_ready_i = 2'b11;
    logic [1:0]  ch_abort_o;
    logic [15:0] sync_err_cnt_o, drop_cnt_o, timeout_cnt_o;

    always #5 clk = ~clk;

    usb_rx_deframer #(
        .NumChannels  (NCH),
        .TimeoutCycles(TMO),
        .SyncByte     (8'hA5)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .ch_data_o     (ch_data_o),
        .ch_valid_o    (ch_valid_o),
        .ch_last_o     (ch_last_o),
        .ch_ready_i    (ch_ready_i),
        .ch_abort_o    (ch_abort_o),
        .sync_err_cnt_o(sync_err_cnt_o),
        .drop_cnt_o    (drop_cnt_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input logic ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (ok === 1'b1) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference model: 0 = hunting, 1 = in payload, 2 = discarding
    int          mst = 0;
    int          mrem = 0;
    int          mch = 0;
    int          idle = 0;
    logic [15:0] e_se = '0, e_dr = '0, e_to = '0;
    logic [1:0]  e_ab = '0;
    logic [32:0] exp_q [2][$];
    int          n_deliv [2];
    int          ab0_seen = 0;
    int          stall_seen = 0;
    bit          tog = 1'b0;

    function automatic logic [15:0] sat(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always @(negedge clk) begin : model
        logic [1:0]  ab_n;
        logic        acc;
        logic [31:0] w;
        if (rst_i) begin
            mst = 0; mrem = 0; mch = 0; idle = 0;
            e_se = '0; e_dr = '0; e_to = '0; e_ab = '0;
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            chk(sync_err_cnt_o == e_se, "sync_err_cnt", 32'(sync_err_cnt_o), 32'(e_se));
            chk(drop_cnt_o == e_dr, "drop_cnt", 32'(drop_cnt_o), 32'(e_dr));
            chk(timeout_cnt_o == e_to, "timeout_cnt", 32'(timeout_cnt_o), 32'(e_to));
            chk(ch_abort_o == e_ab, "abort", 32'(ch_abort_o), 32'(e_ab));
            if (ch_abort_o[0]) ab0_seen++;
            if (ch_valid_o != 2'b00) begin
                chk($countones(ch_valid_o) == 1, "onehot", 32'(ch_valid_o), 32'd1);
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid_o[i]) begin
                    chk(exp_q[i].size() > 0, "unexpected_word", ch_data_o, 32'(i));
                    if (exp_q[i].size() > 0) begin
                        chk({ch_data_o, ch_last_o} === exp_q[i][0], "word_last",
                            {ch_data_o[30:0], ch_last_o}, {exp_q[i][0][31:0]});
                        if (ch_ready_i[i]) begin
                            void'(exp_q[i].pop_front());
                            n_deliv[i]++;
                        end
                    end
                    if (!ch_ready_i[i] && mst == 1) begin
                        stall_seen++;
                        chk(rx_ready_o == 1'b0, "ready_blocked", 32'(rx_ready_o), 32'd0);
                    end
                end
            end
            if (mst != 1) chk(rx_ready_o == 1'b1, "ready_free", 32'(rx_ready_o), 32'd1);
            ab_n = '0;
            acc  = rx_valid_i && rx_ready_o;
            w    = rx_data_i;
            if (acc) begin
                idle = 0;
                if (mst == 0) begin
                    if (w[31:24] != 8'hA5) e_se = sat(e_se);
                    else if (int'(w[23:16]) >= NCH) begin
                        e_dr = sat(e_dr);
                        if (w[15:0] != 0) begin mrem = int'(w[15:0]); mst = 2; end
                    end else if (w[15:0] != 0) begin
                        mch = int'(w[23:16]); mrem = int'(w[15:0]); mst = 1;
                    end
                end else begin
                    if (mst == 1) exp_q[mch].push_back({w, mrem == 1});
                    mrem--;
                    if (mrem == 0) mst = 0;
                end
            end else if (mst != 0 && !rx_valid_i) begin
                idle++;
                if (idle == TMO) begin
                    e_to = sat(e_to);
                    if (mst == 1) ab_n[mch] = 1'b1;
                    mst = 0;
                    idle = 0;
                end
            end
            e_ab = ab_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) ch_ready_i[1] = ~ch_ready_i[1];
    endtask

    task automatic send(input logic [31:0] w);
        logic a;
        bit   done;
        done = 1'b0;
        rx_data_i  = w;
        rx_valid_i = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            a = rx_ready_o;
            step();
            if (a === 1'b1) done = 1'b1;
        end
        if (!done) chk(done, "send_accept", w, 32'd1);
    endtask

    task automatic idle_n(input int n);
        rx_valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk_empty(input string name);
        chk(exp_q[0].size() == 0 && exp_q[1].size() == 0, name,
            32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_deliv[0] = 0;
        n_deliv[1] = 0;
        step();
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk(ch_valid_o == 2'b00 && ch_last_o == 1'b0 && ch_abort_o == 2'b00,
            "reset_outs", {ch_valid_o, ch_abort_o, 27'd0, ch_last_o}, 32'd0);
        chk(ch_data_o == 32'd0, "reset_data", ch_data_o, 32'd0);
        chk(rx_ready_o == 1'b1, "reset_ready", 32'(rx_ready_o), 32'd1);
        step();

        // 1: three words to ch0, first word one cycle after accept
        send(32'hA500_0003);
        send(32'h1111_0001);
        rx_valid_i = 1'b0;
        @(negedge clk);
        chk(ch_valid_o == 2'b01 && ch_data_o == 32'h1111_0001, "first_latency",
            ch_data_o, 32'h1111_0001);
        step();
        send(32'h1111_0002);
        send(32'h1111_0003);
        idle_n(4);
        chk(n_deliv[0] == 3, "t1_deliv", 32'(n_deliv[0]), 32'd3);
        chk_empty("t1_empty");

        // 2: ch1 with toggling ready
        ch_ready_i = 2'b01;
        tog = 1'b1;
        send(32'hA501_0003);
        send(32'h2222_0001);
        send(32'h2222_0002);
        send(32'h2222_0003);
        idle_n(3);
        tog = 1'b0;
        ch_ready_i = 2'b11;
        idle_n(4);
        chk(n_deliv[1] == 3, "t2_deliv", 32'(n_deliv[1]), 32'd3);
        chk(stall_seen > 0, "t2_stalled", 32'(stall_seen), 32'd1);
        chk_empty("t2_empty");

        // 3: garbage before a frame
        repeat (5) send(32'h1234_5678);
        send(32'hA500_0002);
        send(32'h3333_0001);
        send(32'h3333_0002);
        idle_n(4);
        chk(sync_err_cnt_o == 16'd5, "t3_sync", 32'(sync_err_cnt_o), 32'd5);
        chk(n_deliv[0] == 5, "t3_deliv", 32'(n_deliv[0]), 32'd5);

        // 4: unrouted frame absorbed
        send(32'hA507_0002);
        send(32'hDEAD_0001);
        send(32'hDEAD_0002);
        send(32'hA500_0002);
        send(32'h4444_0001);
        send(32'h4444_0002);
        idle_n(4);
        chk(drop_cnt_o == 16'd1, "t4_drop", 32'(drop_cnt_o), 32'd1);
        chk(n_deliv[0] == 7, "t4_deliv", 32'(n_deliv[0]), 32'd7);
        chk_empty("t4_empty");

        // 5: truncated frame times out
        send(32'hA500_0004);
        send(32'h5555_0001);
        send(32'h5555_0002);
        idle_n(TMO + 4);
        chk(timeout_cnt_o == 16'd1, "t5_timeout", 32'(timeout_cnt_o), 32'd1);
        chk(ab0_seen == 1, "t5_abort", 32'(ab0_seen), 32'd1);
        chk(n_deliv[0] == 9, "t5_deliv", 32'(n_deliv[0]), 32'd9);
        send(32'hA501_0001);
        send(32'h5555_0003);
        idle_n(4);
        chk(n_deliv[1] == 4, "t5_next", 32'(n_deliv[1]), 32'd4);

        // 6: zero-length header, reset mid-payload, saturation
        send(32'hA500_0000);
        ch_ready_i = 2'b01;
        send(32'hA501_0003);
        send(32'h6666_0001);
        idle_n(2);
        chk(ch_valid_o == 2'b10, "t6_held", 32'(ch_valid_o), 32'd2);
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        ch_ready_i = 2'b11;
        @(negedge clk);
        chk(ch_valid_o == 2'b00 && ch_data_o == 32'd0 && ch_last_o == 1'b0,
            "t6_rst_outs", ch_data_o, 32'd0);
        chk(sync_err_cnt_o == 16'd0 && drop_cnt_o == 16'd0 && timeout_cnt_o == 16'd0,
            "t6_rst_cnts", 32'(sync_err_cnt_o), 32'd0);
        chk(rx_ready_o == 1'b1, "t6_rst_hunt", 32'(rx_ready_o), 32'd1);
        step();
        for (int k = 0; k < 65536; k++) send(32'h1234_5678);
        idle_n(2);
        chk(sync_err_cnt_o == 16'hFFFF, "t6_saturate", 32'(sync_err_cnt_o), 32'hFFFF);
        send(32'hA500_0001);
        send(32'h7777_0001);
        idle_n(3);
        chk(n_deliv[0] == 10, "t6_after", 32'(n_deliv[0]), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
